// File: rtl/inc_share_pkg.sv
// Shared types, constants and helpers for the time-shared incrementer scheduler.
package inc_share_pkg;

    localparam int NUM_CH_DEF = 3;
    localparam int WIDTH_DEF  = 8;

    typedef logic [WIDTH_DEF-1:0]  count_t;
    typedef logic [NUM_CH_DEF-1:0] ch_mask_t;

    localparam count_t CNT_MAX = '1;

    // Index of the set bit in a one-hot vector of up to 8 channels; 0 when empty.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/inc_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible channel at or after ptr, wrapping.
module rr_arbiter
    import inc_share_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDXW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [IDXW-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDXW-1:0]   idx,
    output logic              any
);

    logic            found;
    logic [IDXW-1:0] cand;
    int              pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        pos   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_CH) pos = pos - NUM_CH;
            cand = IDXW'(pos);
            if (!found && eligible[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign idx = IDXW'(onehot_idx(8'(grant)));
    assign any = |eligible;

endmodule

// File: rtl/inc_share_sched.sv
// NUM_CH count registers sharing one incrementer through a round-robin arbiter.
// Build option: SHARED_INC_SAT_EN saturates counts at all-ones instead of wrapping.
module inc_share_sched
    import inc_share_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       gnt,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       tc_pulse,
    output logic                    busy
);

    localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [WIDTH-1:0] TOP = '1;

    logic [WIDTH-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] grant_oh;
    logic [IDXW-1:0]   grant_idx;
    logic              grant_any;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   ptr_next;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  sum;
    logic              tc_hit;

`ifdef SHARED_INC_SAT_EN
    localparam logic [WIDTH-1:0] NEAR_TOP = TOP - 1'b1;
    logic [NUM_CH-1:0] full;

    always_comb begin
        full = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            full[i] = (cnt[i] == TOP);
        end
    end

    // Saturated channels drop out of arbitration until cleared.
    assign elig   = req & ~clr & ~full;
    assign tc_hit = (operand == NEAR_TOP);
`else
    assign elig   = req & ~clr;
    assign tc_hit = (operand == TOP);
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDXW   (IDXW)
    ) u_arb (
        .eligible (elig),
        .ptr      (ptr),
        .grant    (grant_oh),
        .idx      (grant_idx),
        .any      (grant_any)
    );

    // The single shared incrementer.
    assign operand  = cnt[grant_idx];
    assign sum      = operand + 1'b1;
    assign ptr_next = (grant_idx == IDXW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            gnt      <= '0;
            tc_pulse <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr[i]) begin
                    cnt[i] <= '0;
                end else if (grant_oh[i]) begin
                    cnt[i] <= sum;
                end
            end
            gnt      <= grant_oh;
            tc_pulse <= (grant_any && tc_hit) ? grant_oh : '0;
            busy     <= ($countones(elig) > 1);
            if (grant_any) ptr <= ptr_next;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_count
        assign count[g*WIDTH +: WIDTH] = cnt[g];
    end

endmodule

// File: tb/tb_inc_share_sched.sv
// Scoreboard bench for inc_share_sched: directed scenarios plus random traffic vs. a reference model.
module tb_inc_share_sched;

    localparam int N = 3;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   clr;
    logic [N-1:0]   gnt;
    logic [N*W-1:0] count;
    logic [N-1:0]   tc_pulse;
    logic           busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0]   gnt;
        logic [N*W-1:0] count;
        logic [N-1:0]   tc;
        logic           busy;
    } exp_t;

    exp_t exp_q[$];

    int m_cnt [N];
    int m_ptr;

    inc_share_sched #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .clr      (clr),
        .gnt      (gnt),
        .count    (count),
        .tc_pulse (tc_pulse),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] model_counts();
        logic [N*W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_cnt[i]);
        return v;
    endfunction

    // Reference model: one clock of the scheduler, described from its rules.
    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] c);
        exp_t e;
        bit   elig [N];
        int   n_elig;
        int   win;
        int   maxv;
        maxv   = (1 << W) - 1;
        n_elig = 0;
        for (int i = 0; i < N; i++) begin
            elig[i] = r[i] && !c[i];
`ifdef SHARED_INC_SAT_EN
            if (m_cnt[i] == maxv) elig[i] = 0;
`endif
            if (elig[i]) n_elig++;
        end
        win = -1;
        for (int j = 0; j < N; j++) begin
            int ch;
            ch = (m_ptr + j) % N;
            if (win < 0 && elig[ch]) win = ch;
        end
        e.gnt  = '0;
        e.tc   = '0;
        e.busy = (n_elig > 1);
        if (win >= 0) begin
            e.gnt[win] = 1'b1;
`ifdef SHARED_INC_SAT_EN
            if (m_cnt[win] == maxv - 1) e.tc[win] = 1'b1;
`else
            if (m_cnt[win] == maxv) e.tc[win] = 1'b1;
`endif
            m_cnt[win] = (m_cnt[win] + 1) % (maxv + 1);
            m_ptr      = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) if (c[i]) m_cnt[i] = 0;
        e.count = model_counts();
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] c);
        @(negedge clk);
        req = r;
        clr = c;
        model_step(r, c);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        req   = '0;
        clr   = '0;
        reset = 1'b0;
        #1;
        check({tag, "_count"}, 64'(count), 64'(0));
        check({tag, "_gnt"},   64'(gnt),   64'(0));
        check({tag, "_tc"},    64'(tc_pulse), 64'(0));
        check({tag, "_busy"},  64'(busy),  64'(0));
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: pops the expected response for every clock while out of reset.
    always @(posedge clk) begin
        #1;
        if (reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("gnt",      64'(gnt),      64'(e.gnt));
            check("count",    64'(count),    64'(e.count));
            check("tc_pulse", 64'(tc_pulse), 64'(e.tc));
            check("busy",     64'(busy),     64'(e.busy));
        end
    end

    initial begin
        int drain;
        reset = 1'b0;
        req   = '0;
        clr   = '0;
        m_ptr = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        #12;
        check("por_count", 64'(count), 64'(0));
        check("por_gnt",   64'(gnt),   64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Single requester held: granted every cycle.
        for (int k = 0; k < 4; k++) drive(3'b010, 3'b000);
        settle();
        check("single_count", 64'(count), 64'(24'h000400));

        // Mid-run reset with nonzero counts; contention restarts at channel 0.
        do_reset("rst_mid");
        for (int k = 0; k < 6; k++) drive(3'b111, 3'b000);
        settle();
        check("contend_count", 64'(count), 64'(24'h020202));
        check("contend_busy",  64'(busy),  64'(1));

        // Clear priority over increment.
        drive(3'b000, 3'b111);
        for (int k = 0; k < 5; k++) drive(3'b001, 3'b000);
        drive(3'b011, 3'b001);
        settle();
        check("clrpri_count", 64'(count), 64'(24'h000100));
        check("clrpri_gnt",   64'(gnt),   64'(3'b010));
        drive(3'b011, 3'b000);
        settle();
        check("clrpri_next_gnt", 64'(gnt), 64'(3'b001));

        // Wrap / saturation on channel 2.
        drive(3'b000, 3'b111);
        for (int k = 0; k < 255; k++) drive(3'b100, 3'b000);
        settle();
        check("preload_count2", 64'(count[2*W +: W]), 64'(8'hFF));
        drive(3'b100, 3'b000);
        settle();
`ifdef SHARED_INC_SAT_EN
        check("sat_count2", 64'(count[2*W +: W]), 64'(8'hFF));
        check("sat_gnt",    64'(gnt),             64'(0));
        drive(3'b100, 3'b100);
        settle();
        check("sat_clr_count2", 64'(count[2*W +: W]), 64'(0));
`else
        check("wrap_count2", 64'(count[2*W +: W]), 64'(0));
        check("wrap_tc",     64'(tc_pulse),        64'(3'b100));
        drive(3'b000, 3'b000);
        settle();
        check("wrap_tc_once", 64'(tc_pulse), 64'(0));
`endif

        // Random traffic with rare clears and one mid-run reset.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] r;
            logic [N-1:0] c;
            r = N'($urandom);
            c = '0;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 63) == 0) c[i] = 1'b1;
            drive(r, c);
            if (k == 1500) do_reset("rst_rand");
        end

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
